// File: rtl/mem_bank_freeze_bridge_pkg.sv
// mem_bridge_pkg: shared bank FSM state type and pending-counter sizing for the freeze bridge.
package mem_bridge_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, FROZEN} bank_state_e;
  function automatic int pend_w(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction
endpackage

// File: rtl/mem_bank_freeze_bridge_if.sv
// mem_bank_freeze_bridge_if: multi-bank Avalon-MM bus bundle with master/slave views.
interface mem_bank_freeze_bridge_if #(
  parameter int NUM_BANKS = 2,
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 5
);
  logic [NUM_BANKS-1:0]          read, write, debugaccess, waitrequest, readdatavalid;
  logic [NUM_BANKS*ADDR_W-1:0]   address;
  logic [NUM_BANKS*DATA_W-1:0]   writedata, readdata;
  logic [NUM_BANKS*DATA_W/8-1:0] byteenable;
  logic [NUM_BANKS*BURST_W-1:0]  burstcount;
  modport master(
    output read, write, debugaccess, address, writedata, byteenable, burstcount,
    input  waitrequest, readdatavalid, readdata
  );
  modport slave(
    input  read, write, debugaccess, address, writedata, byteenable, burstcount,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/mem_bank_freeze_bridge_bank.sv
// mem_bridge_bank: one kernel-to-EMIF bank with command register, read credit,
// write-burst tracking and a RUN/DRAIN/FROZEN quiesce FSM.
module mem_bridge_bank
  import mem_bridge_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 32,
  parameter int K_BURST_W   = 5,
  parameter int E_BURST_W   = 7,
  parameter int MAX_PENDING = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze_i,
  input  logic                  k_read_i,
  input  logic                  k_write_i,
  input  logic                  k_dbg_i,
  input  logic [ADDR_W-1:0]     k_addr_i,
  input  logic [DATA_W-1:0]     k_wdata_i,
  input  logic [DATA_W/8-1:0]   k_be_i,
  input  logic [K_BURST_W-1:0]  k_burst_i,
  output logic                  k_wait_o,
  output logic                  k_rdv_o,
  output logic [DATA_W-1:0]     k_rdata_o,
  output logic                  e_read_o,
  output logic                  e_write_o,
  output logic                  e_dbg_o,
  output logic [ADDR_W-1:0]     e_addr_o,
  output logic [DATA_W-1:0]     e_wdata_o,
  output logic [DATA_W/8-1:0]   e_be_o,
  output logic [E_BURST_W-1:0]  e_burst_o,
  input  logic                  e_wait_i,
  input  logic                  e_rdv_i,
  input  logic [DATA_W-1:0]     e_rdata_i,
  output logic                  frozen_o,
  output logic                  idle_o,
  output logic                  ovf_o
);
  localparam int PW = pend_w(MAX_PENDING);
  localparam int SW = PW + K_BURST_W + 1;
  bank_state_e st_q, st_d;
  logic full_q, full_d, rd_q, wr_q, dbg_q, ovf_q, rdv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [K_BURST_W-1:0] burst_q, erem_q, erem_d, krem_q, krem_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [SW-1:0] need;
  logic in_burst, credit_fail, fsm_block, accept, kw_acc, r_acc, w_acc, rdv_hit;
  assign in_burst = erem_q != '0;
  // A read still sitting in the command register already owns credit.
  assign need = SW'(pend_q) + ((full_q & rd_q) ? SW'(burst_q) : SW'(0)) + SW'(k_burst_i);
  assign credit_fail = k_read_i & (need > SW'(MAX_PENDING));
  assign k_wait_o = rst | (full_q & e_wait_i) | credit_fail | fsm_block;
  assign accept = (k_read_i | k_write_i) & ~k_wait_o;
  assign kw_acc = accept & ~k_read_i;
  assign r_acc = full_q & rd_q & ~e_wait_i;
  assign w_acc = full_q & wr_q & ~e_wait_i;
  assign rdv_hit = e_rdv_i & (pend_q != '0);
  always_comb begin
    full_d = accept | (full_q & e_wait_i);
    pend_d = pend_q + (r_acc ? PW'(burst_q) : PW'(0)) - PW'(rdv_hit);
    erem_d = w_acc ? (in_burst ? erem_q - 1'b1 : burst_q - K_BURST_W'(burst_q != '0)) : erem_q;
    krem_d = kw_acc ? (krem_q != '0 ? krem_q - 1'b1 : k_burst_i - K_BURST_W'(k_burst_i != '0)) : krem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      pend_q <= '0;
      erem_q <= '0;
      krem_q <= '0;
      ovf_q  <= 1'b0;
      rdv_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      pend_q <= pend_d;
      erem_q <= erem_d;
      krem_q <= krem_d;
      ovf_q  <= ovf_q | (e_rdv_i & (pend_q == '0));
      rdv_q  <= e_rdv_i;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q    <= k_read_i;
      wr_q    <= k_write_i & ~k_read_i;
      dbg_q   <= k_dbg_i;
      addr_q  <= k_addr_i;
      wdata_q <= k_wdata_i;
      be_q    <= k_be_i;
      burst_q <= k_burst_i;
    end
    if (e_rdv_i) rdata_q <= e_rdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) st_q <= RUN;
    else st_q <= st_d;
  end
  always_comb begin
    st_d = st_q == RUN ? (freeze_i ? DRAIN : RUN) :
           !freeze_i ? RUN :
           (st_q == DRAIN && !full_q && !in_burst && pend_q == '0) ? FROZEN : st_q;
  end
  // While draining, only the tail of a write burst the kernel already started may enter.
  always_comb begin
    fsm_block = st_q == FROZEN || (st_q == DRAIN && !(k_write_i && !k_read_i && krem_q != '0));
    frozen_o  = st_q == FROZEN;
  end
  assign e_read_o  = full_q & rd_q;
  assign e_write_o = full_q & wr_q;
  assign e_dbg_o   = dbg_q;
  assign e_addr_o  = addr_q;
  assign e_wdata_o = wdata_q;
  assign e_be_o    = be_q;
  assign e_burst_o = E_BURST_W'(burst_q);
  assign k_rdv_o   = rdv_q;
  assign k_rdata_o = rdata_q;
  assign idle_o    = ~full_q & (pend_q == '0) & ~in_burst;
  assign ovf_o     = ovf_q;
endmodule

// File: rtl/mem_bank_freeze_bridge.sv
// mem_bank_freeze_bridge: NUM_BANKS independent kernel-to-EMIF bridges with a shared freeze handshake.
module mem_bank_freeze_bridge #(
  parameter int NUM_BANKS   = 2,
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 32,
  parameter int K_BURST_W   = 5,
  parameter int E_BURST_W   = 7,
  parameter int MAX_PENDING = 64
) (
  input  logic                    ddr_clk_clk,
  input  logic                    bridge_reset_reset,
  input  logic                    opencl_freeze,
  output logic                    freeze_ack,
  mem_bank_freeze_bridge_if.slave  kernel,
  mem_bank_freeze_bridge_if.master emif,
  output logic [NUM_BANKS-1:0]    bank_idle,
  output logic [NUM_BANKS-1:0]    rd_overflow_err
);
  localparam int BE_W = DATA_W / 8;
  logic [NUM_BANKS-1:0] frozen;
  logic ack_q;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bridge_bank #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .K_BURST_W(K_BURST_W),
      .E_BURST_W(E_BURST_W), .MAX_PENDING(MAX_PENDING)
    ) u_bank (
      .clk      (ddr_clk_clk),
      .rst      (bridge_reset_reset),
      .freeze_i (opencl_freeze),
      .k_read_i (kernel.read[b]),
      .k_write_i(kernel.write[b]),
      .k_dbg_i  (kernel.debugaccess[b]),
      .k_addr_i (kernel.address[b*ADDR_W +: ADDR_W]),
      .k_wdata_i(kernel.writedata[b*DATA_W +: DATA_W]),
      .k_be_i   (kernel.byteenable[b*BE_W +: BE_W]),
      .k_burst_i(kernel.burstcount[b*K_BURST_W +: K_BURST_W]),
      .k_wait_o (kernel.waitrequest[b]),
      .k_rdv_o  (kernel.readdatavalid[b]),
      .k_rdata_o(kernel.readdata[b*DATA_W +: DATA_W]),
      .e_read_o (emif.read[b]),
      .e_write_o(emif.write[b]),
      .e_dbg_o  (emif.debugaccess[b]),
      .e_addr_o (emif.address[b*ADDR_W +: ADDR_W]),
      .e_wdata_o(emif.writedata[b*DATA_W +: DATA_W]),
      .e_be_o   (emif.byteenable[b*BE_W +: BE_W]),
      .e_burst_o(emif.burstcount[b*E_BURST_W +: E_BURST_W]),
      .e_wait_i (emif.waitrequest[b]),
      .e_rdv_i  (emif.readdatavalid[b]),
      .e_rdata_i(emif.readdata[b*DATA_W +: DATA_W]),
      .frozen_o (frozen[b]),
      .idle_o   (bank_idle[b]),
      .ovf_o    (rd_overflow_err[b])
    );
  end
  always_ff @(posedge ddr_clk_clk) begin
    if (bridge_reset_reset) ack_q <= 1'b0;
    else ack_q <= &frozen;
  end
  assign freeze_ack = ack_q;
endmodule
